move_sequencer: RTL

- Game-side initiator for the move checker.
- Generates pseudo-random one-hot moves and issues each with a one-cycle start pulse plus the current play interval.
- Waits for the checker's ready/correct verdict, then updates score, shortens the interval, and either issues the next move or ends the game.
- Sits between the debounced button/switch front end and the display/score logic.

---
 rtl/move_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - game-side move issuer for the move checker
// Issues LFSR-chosen one-hot moves, consumes verdicts, tracks score and play interval.
module move_sequencer #(
  parameter int          INIT_FREQ = 100000000,
  parameter int          MIN_FREQ  = 25000000,
  parameter int          FREQ_STEP = 2500000,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          SCORE_MAX = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        ready,
  input  logic        correct,
  output logic        start,
  output logic [12:0] move,
  output logic [28:0] play_freq,
  output logic [13:0] score,
  output logic        playing,
  output logic        game_over,
  output logic        round_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    GUARD  = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4,
    OVER   = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [15:0] lfsr, lfsr_n;
  logic        correct_q, correct_q_n;

  logic        start_n;
  logic [12:0] move_n;
  logic [28:0] freq_n;
  logic [13:0] score_n;
  logic        playing_n;
  logic        game_over_n;
  logic        round_done_n;

  logic [3:0]  idx;
  logic [29:0] freq_dec;

  // Free-running so the chosen move depends on when the player acts.
  assign lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign idx    = (lfsr[3:0] >= 4'd13) ? (lfsr[3:0] - 4'd13) : lfsr[3:0];

  // One extra bit keeps the subtraction from wrapping when the interval is small.
  assign freq_dec = {1'b0, play_freq} - 30'(FREQ_STEP);

  always_comb begin
    state_n      = state;
    correct_q_n  = correct_q;
    start_n      = 1'b0;
    move_n       = move;
    freq_n       = play_freq;
    score_n      = score;
    playing_n    = playing;
    game_over_n  = game_over;
    round_done_n = 1'b0;

    case (state)
      IDLE, OVER: begin
        if (state == IDLE) begin
          playing_n = 1'b0;
        end
        if (go) begin
          freq_n      = 29'(INIT_FREQ);
          score_n     = '0;
          game_over_n = 1'b0;
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        move_n    = 13'd1 << idx;
        start_n   = 1'b1;
        playing_n = 1'b1;
        state_n   = GUARD;
      end
      GUARD: begin
        state_n = WAIT;
      end
      WAIT: begin
        if (ready) begin
          correct_q_n  = correct;
          round_done_n = 1'b1;
          state_n      = RESULT;
        end
      end
      RESULT: begin
        if (correct_q) begin
          score_n = (score >= 14'(SCORE_MAX)) ? 14'(SCORE_MAX) : score + 14'd1;
          if ($signed(freq_dec) < $signed(30'(MIN_FREQ))) begin
            freq_n = 29'(MIN_FREQ);
          end else begin
            freq_n = freq_dec[28:0];
          end
          state_n = ISSUE;
        end else begin
          playing_n   = 1'b0;
          game_over_n = 1'b1;
          state_n     = OVER;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= SEED;
      correct_q  <= 1'b0;
      start      <= 1'b0;
      move       <= '0;
      play_freq  <= 29'(INIT_FREQ);
      score      <= '0;
      playing    <= 1'b0;
      game_over  <= 1'b0;
      round_done <= 1'b0;
    end else begin
      state      <= state_n;
      lfsr       <= lfsr_n;
      correct_q  <= correct_q_n;
      start      <= start_n;
      move       <= move_n;
      play_freq  <= freq_n;
      score      <= score_n;
      playing    <= playing_n;
      game_over  <= game_over_n;
      round_done <= round_done_n;
    end
  end

endmodule
